log_operand_encoder: RTL and testbench
======================================

// Module: log_operand_encoder
// PURPOSE
//  Two-stage pipelined Mitchell log encoder directly upstream of the log-domain adder.
//  Takes a pair of unsigned integer operands with a valid/ready handshake.
//  Produces each operand's characteristic (leading-one position) and left-aligned fraction.
//  The adder consumes these to form the approximate product.
// PARAMETERS
//  WIDTH   8                  operand width in bits (>=4, power of two)
//  CHAR_W  $clog2(WIDTH)      characteristic width (3 for WIDTH=8)
//  FRAC_W  WIDTH-1            fraction width (7 for WIDTH=8)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous active-high reset
//  in_valid   in   1       a/b operand pair is valid
//  in_ready   out  1       encoder accepts the pair this cycle
//  a          in   WIDTH   operand A, unsigned
//  b          in   WIDTH   operand B, unsigned
//  out_valid  out  1       encoded pair is valid
//  out_ready  in   1       downstream adder accepts the pair this cycle
//  a_char     out  CHAR_W  index of the MSB set in A
//  a_frac     out  FRAC_W  bits of A below the leading one, MSB-aligned
//  a_zero     out  1       A == 0
//  b_char     out  CHAR_W  index of the MSB set in B
//  b_frac     out  FRAC_W  bits of B below the leading one, MSB-aligned
//  b_zero     out  1       B == 0
// BEHAVIOUR
//  Reset
//   - rst sampled on clk; all valid flags clear.
//   - All data registers reset to 0: out_valid=0, all char/frac/zero outputs=0.
//   - in_ready=1 on the first cycle after reset.
//  Pipeline
//   - S1 registers a/b on an input transfer (in_valid & in_ready).
//   - S2 holds the registered encoding.
//   - Outputs are driven straight from S2 registers.
//   - Latency: 2 cycles from input transfer to out_valid, with out_ready held high.
//   - Throughput: 1 pair per cycle.
//  Handshake
//   - s2_adv = s1_valid & (~s2_valid | out_ready)
//   - in_ready = ~s1_valid | s2_adv  (combinational; no combinational path from in_valid)
//   - While out_valid=1 & out_ready=0, S2 outputs hold stable.
//   - One further pair may sit in S1 during that stall; in_ready then drops to 0.
//   - Simultaneous S2 drain and S1 refill in one cycle: no bubble, no loss, no duplication.
//  Encoding (per operand x, evaluated on S1 contents)
//   - x != 0: char = position of the highest set bit.
//   - x != 0: frac = (x << (FRAC_W-char)) truncated to the low FRAC_W bits; zero=0.
//   - x == 0: char=0, frac=0, zero=1.
//   - x == 1: char=0, frac=0, zero=0. This is the only case separated from zero by the flag.
//  Boundary
//   - rst asserted mid-stream discards any pair held in S1/S2. No output is emitted for it.
//   - in_valid with in_ready=0 is ignored; the source must hold a/b stable.
//   - out_ready is a don't-care while out_valid=0.
// TESTING
//  1. a=8'h6A, b=8'h16, out_ready=1 -> 2 cycles later: a_char=6, a_frac=7'b1010100, b_char=4, b_frac=7'b0110000, zeros=0.
//  2. Back-to-back 6A/16 then 2B/17 -> consecutive cycles: (6,1010100,4,0110000) then (5,0101100,4,0111000).
//  3. a=0, b=8'hFF -> a_zero=1, a_char=0, a_frac=0; b_char=7, b_frac=7'h7F. Also a=1 -> char=0, frac=0, zero=0.
//  4. Stream 4 pairs with out_ready low for 3 cycles mid-burst -> in_ready drops after 2 held pairs, outputs stable, all 4 pairs emitted in order exactly once.
//  5. rst pulsed while 2 pairs are in flight -> next cycle out_valid=0, outputs 0, in_ready=1; the next pair emerges after 2 cycles.
//  6. Random a/b with random in_valid/out_ready for 10k cycles vs reference model -> zero mismatches, no lost or duplicated pairs.

Source files
------------

// File: rtl/log_operand_encoder.sv
// Two-stage Mitchell log encoder. S1 registers the operand pair and S2 registers its
// characteristic/fraction encoding. A valid/ready skid keeps one pair per cycle.
module log_enc_lane #(
  parameter int WIDTH  = 8,
  parameter int CHAR_W = $clog2(WIDTH),
  parameter int FRAC_W = WIDTH-1
) (
  input  logic [WIDTH-1:0]  x,
  output logic [CHAR_W-1:0] chr,
  output logic [FRAC_W-1:0] frac,
  output logic              zero
);
  logic [WIDTH-1:0] sh;

  always_comb begin
    chr = '0;
    for (int i = 0; i < WIDTH; i++)
      if (x[i]) chr = CHAR_W'(i);
    // Shift the leading one up to bit FRAC_W. Only the bits below it are kept.
    sh   = x << (FRAC_W - int'(chr));
    frac = sh[FRAC_W-1:0];
    zero = (x == '0);
  end
endmodule

module log_operand_encoder #(
  parameter int WIDTH  = 8,
  parameter int CHAR_W = $clog2(WIDTH),
  parameter int FRAC_W = WIDTH-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] a_char,
  output logic [FRAC_W-1:0] a_frac,
  output logic              a_zero,
  output logic [CHAR_W-1:0] b_char,
  output logic [FRAC_W-1:0] b_frac,
  output logic              b_zero
);
  localparam int NUM_LANES = 2;

  logic                                s1_valid_q, s1_valid_d;
  logic [NUM_LANES-1:0][WIDTH-1:0]     s1_op_q, s1_op_d;
  logic                                s2_valid_q, s2_valid_d;
  logic [NUM_LANES-1:0][CHAR_W-1:0]    s2_char_q, s2_char_d, enc_char;
  logic [NUM_LANES-1:0][FRAC_W-1:0]    s2_frac_q, s2_frac_d, enc_frac;
  logic [NUM_LANES-1:0]                s2_zero_q, s2_zero_d, enc_zero;
  logic                                s2_adv, in_xfer;

  // Lane 0 is operand A and lane 1 is operand B.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    log_enc_lane #(.WIDTH(WIDTH), .CHAR_W(CHAR_W), .FRAC_W(FRAC_W)) u_enc (
      .x(s1_op_q[l]), .chr(enc_char[l]), .frac(enc_frac[l]), .zero(enc_zero[l])
    );
  end

  assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_adv;
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    s2_char_d  = s2_char_q;
    s2_frac_d  = s2_frac_q;
    s2_zero_d  = s2_zero_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_op_d    = {b, a};
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      s2_char_d  = enc_char;
      s2_frac_d  = enc_frac;
      s2_zero_d  = enc_zero;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_char_q  <= '0;
      s2_frac_q  <= '0;
      s2_zero_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_char_q  <= s2_char_d;
      s2_frac_q  <= s2_frac_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign a_char    = s2_char_q[0];
  assign a_frac    = s2_frac_q[0];
  assign a_zero    = s2_zero_q[0];
  assign b_char    = s2_char_q[1];
  assign b_frac    = s2_frac_q[1];
  assign b_zero    = s2_zero_q[1];
endmodule

// File: tb/tb_log_operand_encoder.sv
// Scoreboard bench for log_operand_encoder: expected encodings are queued on input
// transfer and popped by a monitor on each output transfer.
module tb_log_operand_encoder;
  localparam int W  = 8;
  localparam int CW = 3;
  localparam int FW = 7;
  localparam int VW = 2*(CW+FW+1);

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [CW-1:0] a_char, b_char;
  logic [FW-1:0] a_frac, b_frac;
  logic a_zero, b_zero;

  log_operand_encoder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_char(a_char), .a_frac(a_frac), .a_zero(a_zero),
    .b_char(b_char), .b_frac(b_frac), .b_zero(b_zero)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] held;
  logic stalled = 1'b0;
  wire  [VW-1:0] out_vec = {a_char, a_frac, a_zero, b_char, b_frac, b_zero};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mitchell encoding from the arithmetic definition: char = floor(log2 x).
  function automatic logic [CW+FW:0] enc(input int x);
    int c, f;
    if (x == 0) return {CW'(0), FW'(0), 1'b1};
    c = 0;
    while ((2 ** (c+1)) <= x) c++;
    f = (x - 2 ** c) * (2 ** (FW - c));
    return {CW'(c), FW'(f), 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled <= 1'b0;
    end else begin
      if (stalled) chk("stall_hold", 32'(out_vec), 32'(held));
      if (in_valid && in_ready) exp_q.push_back({enc(int'(a)), enc(int'(b))});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 32'(out_vec), 32'hDEAD);
        else chk("scoreboard", 32'(out_vec), 32'(exp_q.pop_front()));
      end
      stalled <= out_valid & ~out_ready;
      held    <= out_vec;
    end
  end

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
    bit done = 0;
    in_valid = 1'b1; a = va; b = vb;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom % 8)
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return W'(1) << ($urandom % W);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bit acc;
    // Reset state
    tick(2); rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_outputs", 32'(out_vec), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // Test 1: 2-cycle latency and values
    send(8'h6A, 8'h16); idle();
    tick(1);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_vec", 32'(out_vec), 32'({3'd6, 7'b1010100, 1'b0, 3'd4, 7'b0110000, 1'b0}));
    tick(3);

    // Test 2: back to back, values must emerge on consecutive cycles
    send(8'h6A, 8'h16); send(8'h2B, 8'h17); idle();
    chk("t2_first", 32'(out_vec), 32'({3'd6, 7'b1010100, 1'b0, 3'd4, 7'b0110000, 1'b0}));
    tick(1);
    chk("t2_second", 32'(out_vec), 32'({3'd5, 7'b0101100, 1'b0, 3'd4, 7'b0111000, 1'b0}));
    tick(3);

    // Test 3: zero, all-ones, and one
    send(8'h00, 8'hFF); idle(); tick(1);
    chk("t3_zero_ff", 32'(out_vec), 32'({3'd0, 7'd0, 1'b1, 3'd7, 7'h7F, 1'b0}));
    send(8'h01, 8'h01); idle(); tick(1);
    chk("t3_one", 32'(out_vec), 32'({3'd0, 7'd0, 1'b0, 3'd0, 7'd0, 1'b0}));
    tick(3);

    // Test 4: stall with two pairs held
    out_ready = 1'b0;
    send(8'h11, 8'h22); send(8'h33, 8'h44);
    in_valid = 1'b1; a = 8'h55; b = 8'h66;
    @(negedge clk); chk("t4_in_ready_low", 32'(in_ready), 0);
    @(posedge clk); #1;
    tick(2);
    chk("t4_out_valid_held", 32'(out_valid), 1);
    out_ready = 1'b1;
    send(8'h55, 8'h66); send(8'h77, 8'h88); idle();
    tick(4);
    chk("t4_drained", exp_q.size(), 0);

    // Test 5: reset with two pairs in flight
    send(8'h9C, 8'h03); send(8'h40, 8'h0F); idle();
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t5_out_valid", 32'(out_valid), 0);
    chk("t5_outputs", 32'(out_vec), 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    tick(2);
    chk("t5_no_ghost", 32'(out_valid), 0);
    send(8'hC3, 8'h5A); idle(); tick(1);
    chk("t5_latency", 32'(out_valid), 1);
    chk("t5_vec", 32'(out_vec), 32'({enc(8'hC3), enc(8'h5A)}));
    tick(3);

    // Test 6: random traffic with backpressure
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom % 4) != 0;
        a = rnd_op(); b = rnd_op();
      end
      out_ready = ($urandom % 4) != 0;
    end
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk); #1;
    if (!acc && in_valid) begin
      send(a, b);
    end
    idle(); out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    tick(2);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_out_valid_idle", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
